conditional_diff_subtractor_pipe: RTL and testbench



---
 rtl/conditional_diff_subtractor_pipe.sv | 80 ++++++++
 tb/tb_conditional_diff_subtractor_pipe.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/conditional_diff_subtractor_pipe.sv
// conditional_diff_subtractor_pipe: two-stage x - y - bin with the low nibble resolved first and the high nibble chosen from two precomputed candidates.
module conditional_diff_subtractor_pipe (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       bin,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] diff,
    output logic       bout,
    output logic       ovf
);
    function automatic logic [4:0] add4(input logic [3:0] a, input logic [3:0] b, input logic cin);
        logic       c;
        logic [3:0] s;
        c = cin;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        return {c, s};
    endfunction

    logic [4:0] lo, hi0, hi1;
    logic       s1_valid, s2_adv, accept;
    logic [3:0] d_lo, d_hi0, d_hi1, d_hi;
    logic       b4, bo0, bo1, x7, y7, b_sel;

    // Subtraction as x + ~y with carry-in ~bin; every borrow is the inverted carry.
    assign lo  = add4(x[3:0], ~y[3:0], ~bin);
    assign hi0 = add4(x[7:4], ~y[7:4], 1'b1);
    assign hi1 = add4(x[7:4], ~y[7:4], 1'b0);

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !rst && (!s1_valid || s2_adv);
    assign accept   = in_valid && in_ready;
    assign d_hi     = b4 ? d_hi1 : d_hi0;
    assign b_sel    = b4 ? bo1 : bo0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            d_lo      <= '0;
            d_hi0     <= '0;
            d_hi1     <= '0;
            b4        <= 1'b0;
            bo0       <= 1'b0;
            bo1       <= 1'b0;
            x7        <= 1'b0;
            y7        <= 1'b0;
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            s1_valid <= accept || (s1_valid && !s2_adv);
            if (accept) begin
                d_lo  <= lo[3:0];
                b4    <= ~lo[4];
                d_hi0 <= hi0[3:0];
                bo0   <= ~hi0[4];
                d_hi1 <= hi1[3:0];
                bo1   <= ~hi1[4];
                x7    <= x[7];
                y7    <= y[7];
            end
            if (s2_adv)
                out_valid <= s1_valid;
            if (s2_adv && s1_valid) begin
                diff <= {d_hi, d_lo};
                bout <= b_sel;
                ovf  <= (x7 != y7) && (d_hi[3] != x7);
            end
        end
    end
endmodule

// File: tb/tb_conditional_diff_subtractor_pipe.sv
// tb_conditional_diff_subtractor_pipe: table vectors, stall/reset sequences and a random stream against an integer reference model.
module tb_conditional_diff_subtractor_pipe;
    logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0, bin = 1'b0;
    logic [7:0] x = '0, y = '0;
    logic       in_ready, out_valid, bout, ovf;
    logic [7:0] diff;

    conditional_diff_subtractor_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y), .bin(bin),
        .out_valid(out_valid), .out_ready(out_ready), .diff(diff), .bout(bout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] x, y;
        logic       bin;
        logic [7:0] d;
        logic       b, o;
    } vec_t;

    int         passed = 0, total = 0, n_in = 0, n_out = 0;
    logic [9:0] q[$];
    logic [7:0] got[$];
    vec_t       vt[8];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference: plain integer subtraction; overflow means the signed result leaves [-128,127].
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic c);
        int u, s;
        u = int'(a) - int'(b) - int'(c);
        s = int'($signed(a)) - int'($signed(b)) - int'(c);
        return {(s < -128) || (s > 127), u < 0, u[7:0]};
    endfunction

    // Called at a falling edge: observes handshakes just before the next rising edge.
    task automatic tick(output logic acc);
        #1;
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            n_out++;
            got.push_back(diff);
            if (q.size() == 0) chk("unexpected_beat", 1, 0);
            else chk("stream_result", int'({ovf, bout, diff}), int'(q.pop_front()));
        end
        if (acc) begin
            n_in++;
            q.push_back(model(x, y, bin));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic c);
        logic acc;
        int   g;
        x = a; y = b; bin = c; in_valid = 1'b1;
        g = 0;
        do begin
            tick(acc);
            g++;
        end while (!acc && g < 50);
        if (!acc) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        logic acc;
        int   g;
        in_valid = 1'b0; out_ready = 1'b1;
        g = 0;
        while (q.size() > 0 && g < 50) begin
            tick(acc);
            g++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        logic acc;
        int   sent;
        vt[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vt[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vt[2] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
        vt[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vt[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vt[5] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vt[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vt[7] = '{8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1};

        @(negedge clk);
        #1;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_in_ready", int'(in_ready), 0);
        chk("reset_diff", int'({ovf, bout, diff}), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("in_ready_after_reset", int'(in_ready), 1);
        @(negedge clk);

        out_ready = 1'b1;
        foreach (vt[i]) begin
            x = vt[i].x; y = vt[i].y; bin = vt[i].bin; in_valid = 1'b1;
            tick(acc);
            chk("vec_accept", int'(acc), 1);
            in_valid = 1'b0;
            chk("vec_not_yet_valid", int'(out_valid), 0);
            tick(acc);
            chk("vec_out_valid", int'(out_valid), 1);
            chk("vec_diff", int'(diff), int'(vt[i].d));
            chk("vec_bout", int'(bout), int'(vt[i].b));
            chk("vec_ovf", int'(ovf), int'(vt[i].o));
            tick(acc);
            chk("vec_valid_one_cycle", int'(out_valid), 0);
        end

        got.delete();
        x = 8'h20; y = 8'h01; bin = 1'b0; in_valid = 1'b1;
        tick(acc);
        x = 8'h30; y = 8'h02;
        tick(acc);
        out_ready = 1'b0;
        x = 8'h40; y = 8'h03;
        for (int i = 0; i < 3; i++) begin
            tick(acc);
            chk("stall_no_accept", int'(acc), 0);
            chk("stall_hold_diff", int'(diff), 'h1F);
            chk("stall_hold_valid", int'(out_valid), 1);
        end
        out_ready = 1'b1;
        send(8'h40, 8'h03, 1'b0);
        drain();
        chk("stall_count", got.size(), 3);
        if (got.size() == 3) begin
            chk("stall_order_a", int'(got[0]), 'h1F);
            chk("stall_order_b", int'(got[1]), 'h2E);
            chk("stall_order_c", int'(got[2]), 'h3D);
        end

        out_ready = 1'b0;
        send(8'h55, 8'h11, 1'b0);
        send(8'h66, 8'h22, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", int'(out_valid), 0);
        chk("async_rst_result", int'({ovf, bout, diff}), 0);
        chk("async_rst_in_ready", int'(in_ready), 0);
        q.delete();
        n_in = 0; n_out = 0;
        @(negedge clk);
        chk("rst_hold_in_ready", int'(in_ready), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        got.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick(acc);
        chk("no_stale_beats", got.size(), 0);
        send(8'h09, 8'h04, 1'b0);
        drain();
        chk("post_rst_count", got.size(), 1);
        if (got.size() == 1) chk("post_rst_diff", int'(got[0]), 'h05);

        sent = 0;
        n_in = 0; n_out = 0;
        in_valid = 1'b0;
        while (sent < 20000) begin
            if (!in_valid && $urandom_range(3) != 0) begin
                in_valid = 1'b1;
                x = 8'($urandom);
                y = 8'($urandom);
                bin = 1'($urandom);
            end
            out_ready = 1'($urandom);
            tick(acc);
            if (acc) begin
                sent++;
                in_valid = 1'b0;
            end
        end
        drain();
        chk("beats_in", n_in, 20000);
        chk("beats_in_eq_out", n_out, n_in);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
